fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC loaded at reset.
REQ-002 Parameter DEPTH, default 2, fetch buffer entries; legal range 2..8.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 imem_req  out  1  instruction memory read request, held until acknowledged.
REQ-006 imem_addr  out  32  read address, stable while imem_req=1.
REQ-007 imem_ack  in  1  memory response valid; meaningful only while imem_req=1.
REQ-008 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-009 redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-010 redirect_pc  in  32  redirect target, valid with redirect.
REQ-011 stall  in  1  downstream IF/ID hold; head entry not consumed.
REQ-012 valid  out  1  npc/instr carry a real instruction.
REQ-013 npc  out  32  fetch address of head entry plus 4.
REQ-014 instr  out  32  instruction word of head entry.

Function
REQ-015 Internal state: pc (32b), FIFO of DEPTH {npc,instr} entries, count (0..DEPTH), FSM {RUN, WAIT, DROP}.
REQ-016 imem_req SHALL be 1 exactly when FSM is WAIT or DROP; imem_addr SHALL equal the registered request address.
REQ-017 Single outstanding request only; no new address issued until the current one is acked.
REQ-018 pop = valid & ~stall; valid = (count != 0); when count=0, npc=32'h0 and instr=32'h00000000 (NOP bubble).
REQ-019 RUN: if ~redirect and count < DEPTH, latch imem_addr<=pc, go WAIT; else stay RUN.
REQ-020 WAIT, ack, no redirect: push {pc+4, imem_rdata}, pc<=pc+4; if count+1-pop < DEPTH, stay WAIT with imem_addr<=pc+4 (back-to-back), else go RUN.
REQ-021 WAIT, no ack, no redirect: hold state and address.
REQ-022 DROP: on ack discard imem_rdata, go RUN; without ack stay DROP.
REQ-023 redirect (any state) has priority over push/pop: FIFO flushed (count<=0), pc<=redirect_pc, no push that cycle.
REQ-024 redirect in WAIT without ack, or in DROP without ack -> DROP; with ack same cycle -> data discarded, go RUN.
REQ-025 redirect in RUN -> stays RUN; first request to redirect_pc issued next cycle.
REQ-026 Push and pop in same cycle: count unchanged; FIFO SHALL accept push when full only if pop occurs that cycle.
REQ-027 Address arithmetic modulo 2^32; pc+4 from 32'hFFFFFFFC wraps to 32'h00000000.
REQ-028 Outputs npc/instr/valid SHALL be driven directly from FIFO head registers (no combinational path from imem_rdata).
REQ-029 Minimum latency: reset release to first valid = 2 cycles plus memory latency (request cycle, ack cycle, head visible next cycle).

Reset
REQ-030 With reset=0 at a rising edge: pc<=RESET_PC, count<=0, FSM<=RUN, imem_addr<=32'h0; hence imem_req=0, valid=0, npc=0, instr=0.
REQ-031 Reset mid-request abandons the outstanding access; an imem_ack arriving while imem_req=0 SHALL be ignored.
REQ-032 Reset overrides redirect, stall and ack in the same cycle.

Verification
REQ-033 Reset release, 1-cycle memory returning addr-based words, stall=0 -> imem_addr 0,4,8,... back-to-back; valid stream npc=4,8,12 with matching instr.
REQ-034 stall=1 held 5 cycles with 1-cycle memory -> count reaches 2, imem_req drops, head npc/instr unchanged; release -> sequential order preserved, no duplicate or lost entry.
REQ-035 3-cycle memory, redirect to 32'h00000100 one cycle after request -> FSM DROP, stale word never output; next imem_addr=32'h100, first valid npc=32'h104.
REQ-036 redirect coincident with imem_ack and full FIFO -> count=0, ack data discarded, next imem_addr=redirect_pc.
REQ-037 RESET_PC=32'hFFFFFFFC -> first npc=32'h00000000, second imem_addr=32'h00000000.
REQ-038 reset asserted while WAIT with ack pending; ack pulsed after reset release with imem_req=0 -> no push, valid=0 until new request acked.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read at a time, results
// queued in a small {npc, instr} FIFO that feeds the IF/ID stage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        valid,
    output logic [31:0] npc,
    output logic [31:0] instr,
    output logic [1:0]  fsm_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [31:0]     pc_next;
    logic [31:0]     pc_plus4;
    logic [31:0]     addr_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   count_if_push;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [31:0]     npc_mem   [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            push;
    logic            pop;
    logic            flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pc_plus4      = pc + 32'd4;
    assign valid         = (count != '0);
    assign pop           = valid & ~stall;
    assign npc           = valid ? npc_mem[head] : 32'h0;
    assign instr         = valid ? instr_mem[head] : 32'h0;
    assign imem_req      = (state == S_WAIT) || (state == S_DROP);
    assign fsm_state     = state;
    assign count_if_push = count + CW'(1) - CW'(pop);

    // Redirect wins over everything; an unacked request in flight must still
    // be drained, which is what DROP does.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = imem_addr;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush   = 1'b1;
            pc_next = redirect_pc;
            case (state)
                S_WAIT, S_DROP: state_next = imem_ack ? S_RUN : S_DROP;
                default:        state_next = S_RUN;
            endcase
        end else begin
            case (state)
                S_RUN: begin
                    if (count < CW'(DEPTH)) begin
                        addr_next  = pc;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        push    = 1'b1;
                        pc_next = pc_plus4;
                        if (count_if_push < CW'(DEPTH)) begin
                            addr_next = pc_plus4;
                        end else begin
                            state_next = S_RUN;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RUN;
            pc        <= RESET_PC;
            imem_addr <= 32'h0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
            count     <= count_next;
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= ptr_inc(tail);
                if (pop)  head <= ptr_inc(head);
            end
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            npc_mem[tail]   <= pc_plus4;
            instr_mem[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, expected head entries queued by the
// stimulus and compared by an independent monitor whenever an entry is consumed.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid;
    logic [31:0] npc;
    logic [31:0] instr;
    logic [1:0]  fsm_state;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_stall;
    logic        w_valid;
    logic [31:0] w_npc;
    logic [31:0] w_instr;
    logic [1:0]  w_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 1;
    int          cnt      = 0;
    bit          mem_on   = 1'b0;
    bit          force_ack = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .valid(valid), .npc(npc),
        .instr(instr), .fsm_state(fsm_state)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .stall(w_stall), .valid(w_valid), .npc(w_npc),
        .instr(w_instr), .fsm_state(w_state)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [31:0] e_npc, input logic [31:0] e_instr);
        exp_q.push_back({e_npc, e_instr});
    endtask

    task automatic do_reset(input bit stall_at_release);
        reset     = 1'b0;
        mem_on    = 1'b0;
        redirect  = 1'b0;
        force_ack = 1'b0;
        stall     = 1'b0;
        tick(3);
        check("reset_req", imem_req, 0);
        check("reset_addr", imem_addr, 0);
        check("reset_valid", valid, 0);
        check("reset_head", {npc, instr}, 0);
        stall  = stall_at_release;
        reset  = 1'b1;
        mem_on = 1'b1;
    endtask

    // Memory models: main port has programmable latency, wrap instance acks at once.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        w_ack      = 1'b0;
        w_rdata    = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_on) begin
                cnt      = 0;
                imem_ack = 1'b0;
            end else begin
                if (imem_ack) cnt = 0;
                if (imem_req) begin
                    cnt++;
                    if (cnt >= lat) begin
                        imem_ack   = 1'b1;
                        imem_rdata = word(imem_addr);
                    end else begin
                        imem_ack   = 1'b0;
                        imem_rdata = 32'hBAD00000;
                    end
                end else begin
                    cnt      = 0;
                    imem_ack = 1'b0;
                end
            end
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end
            w_ack   = w_req;
            w_rdata = word(w_addr);
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset && valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got npc=%h instr=%h, expected none", npc, instr);
                end else begin
                    e = exp_q.pop_front();
                    check("stream", {npc, instr}, e);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        stall         = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_stall       = 1'b0;

        // Sequential stream, stall hold, and wrap of the reset pc
        lat = 1;
        push_exp(32'd4,  word(32'd0));
        push_exp(32'd8,  word(32'd4));
        push_exp(32'd12, word(32'd8));
        push_exp(32'd16, word(32'd12));
        push_exp(32'd20, word(32'd16));
        do_reset(1'b0);
        tick();
        check("a_addr0", {imem_req, imem_addr}, {1'b1, 32'h0});
        check("a_valid_latency", valid, 0);
        check("wrap_addr0", w_addr, 32'hFFFFFFFC);
        tick();
        check("a_addr4", imem_addr, 32'd4);
        check("a_first_valid", valid, 1);
        check("wrap_addr1", w_addr, 32'h0);
        check("wrap_first_head", {w_valid, w_npc, w_instr}, {1'b1, 32'h0, word(32'hFFFFFFFC)});
        tick();
        check("a_addr8", imem_addr, 32'd8);
        tick();
        stall = 1'b1;
        tick();
        check("a_full_run", fsm_state, 0);
        tick(2);
        check("a_stall_req", imem_req, 0);
        check("a_stall_head", {valid, npc, instr}, {1'b1, 32'd12, word(32'd8)});
        tick(2);
        check("a_stall_head_late", {npc, instr}, {32'd12, word(32'd8)});
        stall = 1'b0;
        tick(3);
        mem_on = 1'b0;
        tick(4);
        check("a_drained", exp_q.size(), 0);
        check("a_pending_addr", {imem_req, imem_addr}, {1'b1, 32'd20});

        // Redirect one cycle into a slow access: stale word is dropped
        lat = 3;
        push_exp(32'h104, word(32'h100));
        do_reset(1'b0);
        tick();
        check("b_addr0", {imem_req, imem_addr}, {1'b1, 32'h0});
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("b_drop_state", fsm_state, 2);
        check("b_drop_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        tick(2);
        check("b_after_drop", {imem_req, valid}, 0);
        tick();
        check("b_redirect_addr", {imem_req, imem_addr}, {1'b1, 32'h100});
        tick(3);
        mem_on = 1'b0;
        tick(3);
        check("b_drained", exp_q.size(), 0);
        check("b_pending_addr", imem_addr, 32'h104);

        // Redirect on the same edge as an ack that would fill the buffer
        lat = 1;
        push_exp(32'h2004, word(32'h2000));
        do_reset(1'b1);
        tick(2);
        check("c_stalled_head", {valid, npc, instr}, {1'b1, 32'd4, word(32'd0)});
        redirect    = 1'b1;
        redirect_pc = 32'h2000;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("c_flushed", {valid, imem_req, fsm_state}, 0);
        tick();
        check("c_redirect_addr", {imem_req, imem_addr}, {1'b1, 32'h2000});
        tick();
        mem_on = 1'b0;
        tick(3);
        check("c_drained", exp_q.size(), 0);

        // Reset with an ack pending, then a stray ack while no request is out
        lat = 2;
        push_exp(32'd4, word(32'd0));
        do_reset(1'b0);
        tick();
        check("d_addr0", {imem_req, imem_addr}, {1'b1, 32'h0});
        reset = 1'b0;
        tick();
        check("d_reset_mid", {imem_req, valid, fsm_state, imem_addr}, 0);
        reset     = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("d_stray_ack_ignored", valid, 0);
        check("d_new_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        tick();
        check("d_still_empty", valid, 0);
        tick();
        mem_on = 1'b0;
        tick(3);
        check("d_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
